gtx_link_monitor: RTL

- Supervises one GTX lane after bring-up and sits directly upstream of the GTX reset sequencer.
- Drives that sequencer's `request` input and consumes its `start` output.
- Requests a reset when:
  - lock is not reached in time,
  - a status bit drops while the link is up, or
  - the error rate exceeds a threshold.
- Retries are counted and the block stops in FAIL after MAX_RETRY consecutive automatic attempts.

---
 rtl/gtx_link_pkg.sv | 28 ++
 rtl/gtx_status_sync.sv | 23 ++
 rtl/gtx_link_monitor.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/gtx_link_pkg.sv
// gtx_link_pkg: state encoding, default parameters and shared widths for the GTX link monitor.
package gtx_link_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        LINK_UP   = 3'd2,
        REQ       = 3'd3,
        WAIT_DROP = 3'd4,
        FAIL      = 3'd5
    } link_state_e;

    localparam int unsigned DEF_LOCK_TIMEOUT  = 10000000;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_ERR_WINDOW    = 65536;
    localparam int unsigned DEF_ERR_THRESH    = 16;
    localparam int unsigned DEF_REQ_CYCLES    = 16;
    localparam int unsigned DEF_MAX_RETRY     = 8;

    localparam int unsigned RETRY_W = 8;
    localparam int unsigned ERR_W   = 16;
    localparam int unsigned LDC_W   = 16;

    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gtx_status_sync.sv
// gtx_status_sync: W-bit two-flop synchroniser for asynchronous status levels, resets to 0.
module gtx_status_sync #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gtx_link_monitor.sv
// gtx_link_monitor: supervises one GTX lane and requests resets from the reset sequencer.
// Define GTX_LINK_STATS_EN to enable the saturating link_down_cnt statistic.
module gtx_link_monitor
    import gtx_link_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned ERR_WINDOW    = DEF_ERR_WINDOW,
    parameter int unsigned ERR_THRESH    = DEF_ERR_THRESH,
    parameter int unsigned REQ_CYCLES    = DEF_REQ_CYCLES,
    parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               plllkdet,
    input  logic               tx_resetdone,
    input  logic               rx_resetdone,
    input  logic               rx_byteisaligned,
    input  logic               rx_err,
    input  logic               force_req,
    output logic               request,
    output logic               link_up,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LDC_W-1:0]   link_down_cnt
);

    localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned WIN_W = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int unsigned REQ_W = $clog2(REQ_CYCLES + 1);

    link_state_e        state_q, state_d;
    logic [31:0]        tmo_q, tmo_d;
    logic [STB_W-1:0]   stb_q, stb_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [ERR_W-1:0]   err_q, err_d, err_nxt;
    logic [REQ_W-1:0]   rcnt_q, rcnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [3:0]         sync_q;
    logic               stat_ok, win_wrap, auto_req;

    gtx_status_sync #(.W(4)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({plllkdet, tx_resetdone, rx_resetdone, rx_byteisaligned}),
        .q     (sync_q)
    );

    assign stat_ok   = &sync_q;
    assign win_wrap  = win_q == WIN_W'(ERR_WINDOW - 1);
    // an error in the wrap cycle already belongs to the new window
    assign err_nxt   = (win_wrap ? '0 : err_q) + ERR_W'(rx_err);
    assign retry_cnt = retry_q;

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        stb_d    = stb_q;
        win_d    = win_q;
        err_d    = err_q;
        rcnt_d   = rcnt_q;
        retry_d  = retry_q;
        auto_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_LOCK;
                    tmo_d   = '0;
                    stb_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (stat_ok && stb_q == STB_W'(STABLE_CYCLES - 1)) begin
                    state_d = LINK_UP;
                    retry_d = '0;
                    win_d   = '0;
                    err_d   = '0;
                end else if (tmo_q == 32'(LOCK_TIMEOUT - 1)) begin
                    auto_req = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    stb_d = stat_ok ? stb_q + 1'b1 : '0;
                end
            end
            LINK_UP: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (!stat_ok || err_nxt == ERR_W'(ERR_THRESH)) begin
                    auto_req = 1'b1;
                end else begin
                    win_d = win_wrap ? '0 : win_q + 1'b1;
                    err_d = err_nxt;
                end
            end
            REQ: begin
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == REQ_W'(REQ_CYCLES - 1)) state_d = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (!start) state_d = IDLE;
            end
            FAIL: ;
            default: state_d = IDLE;
        endcase
        if (auto_req) begin
            if (MAX_RETRY != 0 && retry_q == RETRY_W'(MAX_RETRY)) begin
                state_d = FAIL;
            end else begin
                state_d = REQ;
                retry_d = retry_inc(retry_q);
                rcnt_d  = '0;
            end
        end
        // software request overrides every automatic cause and does not count as a retry
        if (force_req && state_q != REQ) begin
            state_d = REQ;
            retry_d = '0;
            rcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            stb_q   <= '0;
            win_q   <= '0;
            err_q   <= '0;
            rcnt_q  <= '0;
            retry_q <= '0;
            request <= 1'b0;
            link_up <= 1'b0;
            fail    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            stb_q   <= stb_d;
            win_q   <= win_d;
            err_q   <= err_d;
            rcnt_q  <= rcnt_d;
            retry_q <= retry_d;
            request <= state_d == REQ;
            link_up <= state_d == LINK_UP;
            fail    <= state_d == FAIL;
        end
    end

`ifdef GTX_LINK_STATS_EN
    logic [LDC_W-1:0] ldc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldc_q <= '0;
        end else if (state_q == LINK_UP && state_d != LINK_UP && !(&ldc_q)) begin
            ldc_q <= ldc_q + 1'b1;
        end
    end

    assign link_down_cnt = ldc_q;
`else
    assign link_down_cnt = '0;
`endif

endmodule
